// File: rtl/full_matrix_chain_if.sv
// Bus between the forward-kinematics accumulator and its neighbours: start
// request, per-joint link transforms in, cumulative transforms and status out.
interface full_matrix_chain_if #(
  parameter int W = 27
);
  logic                            en;
  logic [5:0][3:0][3:0][W-1:0]     link_matrix;
  logic [5:0][3:0][3:0][W-1:0]     full_matrix;
  logic                            busy;
  logic                            done;
  logic                            overflow;

  modport master (
    output en, link_matrix,
    input  full_matrix, busy, done, overflow
  );

  modport slave (
    input  en, link_matrix,
    output full_matrix, busy, done, overflow
  );
endinterface

// File: rtl/full_matrix_chain.sv
// Forward-kinematics accumulator: builds T0, T0*T1, ... T0*..*T5 one element
// per cycle from four shared signed multipliers, saturating each result.
module full_matrix_chain #(
  parameter int W    = 27,
  parameter int FRAC = 18
) (
  input logic                clk,
  input logic                rst,
  full_matrix_chain_if.slave bus
);
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_MUL, S_DONE} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [2:0]                  r_i;
  logic [1:0]                  r_r;
  logic [1:0]                  r_c;
  logic [5:0][3:0][3:0][W-1:0] r_full;
  logic                        r_ovf;

  logic [2:0]                  w_prev;
  logic signed [W-1:0]         w_a [4];
  logic signed [W-1:0]         w_b [4];
  logic signed [PW-1:0]        w_prod [4];
  logic signed [SW-1:0]        w_sum;
  logic signed [SW-1:0]        w_shift;
  logic signed [W-1:0]         w_elem;
  logic                        w_clamp;
  logic                        w_last;

  function automatic logic signed [SW-1:0] f_scale(input logic signed [SW-1:0] v);
    return v >>> FRAC;
  endfunction

  // Representable iff every bit above the W-bit sign position matches the sign.
  function automatic logic f_out_of_range(input logic signed [SW-1:0] v);
    return !((&v[SW-1:W-1]) || !(|v[SW-1:W-1]));
  endfunction

  function automatic logic signed [W-1:0] f_sat(input logic signed [SW-1:0] v);
    if (!f_out_of_range(v)) return v[W-1:0];
    else if (v[SW-1])       return {1'b1, {(W-1){1'b0}}};
    else                    return {1'b0, {(W-1){1'b1}}};
  endfunction

  assign w_prev = r_i - 3'd1;
  assign w_last = (r_i == 3'd5) && (r_r == 2'd3) && (r_c == 2'd3);

  // Stage: row of the previous cumulative transform times column of link i.
  always_comb begin
    w_sum = '0;
    for (int m = 0; m < 4; m++) begin
      w_a[m]    = r_full[w_prev][r_r][2'(m)];
      w_b[m]    = bus.link_matrix[r_i][2'(m)][r_c];
      w_prod[m] = PW'(w_a[m]) * PW'(w_b[m]);
      w_sum     = w_sum + SW'(w_prod[m]);
    end
    w_shift = f_scale(w_sum);
    w_elem  = f_sat(w_shift);
    w_clamp = f_out_of_range(w_shift);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.en) w_next = S_COPY;
      S_COPY:  w_next = S_MUL;
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row-major walk over joints 1..5; joint index stays in range after the last write.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_COPY) begin
      r_i <= 3'd1;
      r_r <= 2'd0;
      r_c <= 2'd0;
    end else if (r_state == S_MUL) begin
      r_c <= r_c + 2'd1;
      if (r_c == 2'd3) begin
        r_r <= r_r + 2'd1;
        if (r_r == 2'd3 && !w_last) r_i <= r_i + 3'd1;
      end
    end
  end

  // Stage: result write-back; unwritten elements keep the previous run's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else if (r_state == S_COPY) begin
      r_full[0] <= bus.link_matrix[0];
    end else if (r_state == S_MUL) begin
      r_full[r_i][r_r][r_c] <= w_elem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_ovf <= 1'b0;
    else if (r_state == S_IDLE && bus.en) r_ovf <= 1'b0;
    else if (r_state == S_MUL && w_clamp) r_ovf <= 1'b1;
  end

  assign bus.full_matrix = r_full;
  assign bus.busy        = (r_state == S_COPY) || (r_state == S_MUL);
  assign bus.done        = (r_state == S_DONE);
  assign bus.overflow    = r_ovf;
endmodule
